// File: rtl/imm_extend_queue.sv
// Buffered LEGv8 immediate extender: decodes each accepted instruction into a
// width-generalised immediate and queues {imm, fmt, instr} in a DEPTH-entry FIFO.
module imm_extend_queue #(
  parameter int XLEN         = 64,
  parameter int DEPTH        = 4,
  parameter int SCALE_BRANCH = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_imm,
  output logic [2:0]                 out_fmt,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_B    = 3'd1;
  localparam logic [2:0] FMT_CB   = 3'd2;
  localparam logic [2:0] FMT_D    = 3'd3;
  localparam logic [2:0] FMT_I    = 3'd4;

  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] dec_ext;
  logic [XLEN-1:0] dec_imm;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    dec_fmt = FMT_NONE;
    dec_ext = '0;
    if (in_instr[31:26] == 6'b000101) begin
      dec_fmt = FMT_B;
      dec_ext = {{(XLEN-26){in_instr[25]}}, in_instr[25:0]};
    end else if (in_instr[31:25] == 7'b1011010) begin
      dec_fmt = FMT_CB;
      dec_ext = {{(XLEN-19){in_instr[23]}}, in_instr[23:5]};
    end else if (in_instr[31:21] == 11'b11111000010 || in_instr[31:21] == 11'b11111000000) begin
      dec_fmt = FMT_D;
      dec_ext = {{(XLEN-9){in_instr[20]}}, in_instr[20:12]};
    end else if (in_instr[31:22] == 10'b1001000100) begin
      dec_fmt = FMT_I;
      dec_ext = {{(XLEN-12){1'b0}}, in_instr[21:10]};
    end
  end

  // Shift at full width: XLEN >= 32 leaves spare sign bits, so nothing is lost.
  always_comb begin
    dec_imm = dec_ext;
    if (SCALE_BRANCH != 0 && (dec_fmt == FMT_B || dec_fmt == FMT_CB))
      dec_imm = dec_ext << 2;
  end

  logic [XLEN-1:0] mem_imm   [DEPTH];
  logic [2:0]      mem_fmt   [DEPTH];
  logic [31:0]     mem_instr [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // NOTE: storage has no reset; occupancy is tracked by count, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_imm[wr_ptr]   <= dec_imm;
      mem_fmt[wr_ptr]   <= dec_fmt;
      mem_instr[wr_ptr] <= in_instr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign out_imm   = out_valid ? mem_imm[rd_ptr]   : '0;
  assign out_fmt   = out_valid ? mem_fmt[rd_ptr]   : 3'd0;
  assign out_instr = out_valid ? mem_instr[rd_ptr] : 32'd0;

endmodule
